// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction front end.
//   - Internal opcode codes (lui=1 .. and=37, 0 = unrecognised), shared with
//     the decoder, reservation station, load/store buffer and reorder buffer.
//   - Raw RISC-V major opcode field values (inst[6:0]).
//   - Fetch state machine encoding.
package instruction_fetcher_pkg;

  localparam int unsigned OPC_W = 7;
  typedef logic [OPC_W-1:0] op_code_t;

  localparam op_code_t OP_NONE  = 7'd0;
  localparam op_code_t OP_LUI   = 7'd1;
  localparam op_code_t OP_AUIPC = 7'd2;
  localparam op_code_t OP_JAL   = 7'd3;
  localparam op_code_t OP_JALR  = 7'd4;
  localparam op_code_t OP_BEQ   = 7'd5;
  localparam op_code_t OP_BNE   = 7'd6;
  localparam op_code_t OP_BLT   = 7'd7;
  localparam op_code_t OP_BGE   = 7'd8;
  localparam op_code_t OP_BLTU  = 7'd9;
  localparam op_code_t OP_BGEU  = 7'd10;
  localparam op_code_t OP_LB    = 7'd11;
  localparam op_code_t OP_LH    = 7'd12;
  localparam op_code_t OP_LW    = 7'd13;
  localparam op_code_t OP_LBU   = 7'd14;
  localparam op_code_t OP_LHU   = 7'd15;
  localparam op_code_t OP_SB    = 7'd16;
  localparam op_code_t OP_SH    = 7'd17;
  localparam op_code_t OP_SW    = 7'd18;
  localparam op_code_t OP_ADDI  = 7'd19;
  localparam op_code_t OP_SLTI  = 7'd20;
  localparam op_code_t OP_SLTIU = 7'd21;
  localparam op_code_t OP_XORI  = 7'd22;
  localparam op_code_t OP_ORI   = 7'd23;
  localparam op_code_t OP_ANDI  = 7'd24;
  localparam op_code_t OP_SLLI  = 7'd25;
  localparam op_code_t OP_SRLI  = 7'd26;
  localparam op_code_t OP_SRAI  = 7'd27;
  localparam op_code_t OP_ADD   = 7'd28;
  localparam op_code_t OP_SUB   = 7'd29;
  localparam op_code_t OP_SLL   = 7'd30;
  localparam op_code_t OP_SLT   = 7'd31;
  localparam op_code_t OP_SLTU  = 7'd32;
  localparam op_code_t OP_XOR   = 7'd33;
  localparam op_code_t OP_SRL   = 7'd34;
  localparam op_code_t OP_SRA   = 7'd35;
  localparam op_code_t OP_OR    = 7'd36;
  localparam op_code_t OP_AND   = 7'd37;

  // Raw major opcodes, inst[6:0].
  localparam logic [6:0] RV_LUI    = 7'b0110111;
  localparam logic [6:0] RV_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_JAL    = 7'b1101111;
  localparam logic [6:0] RV_JALR   = 7'b1100111;
  localparam logic [6:0] RV_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_STORE  = 7'b0100011;
  localparam logic [6:0] RV_OPIMM  = 7'b0010011;
  localparam logic [6:0] RV_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_JALR  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_decoder.sv
// Combinational RV32I decoder.
//   inst_i    : raw 32-bit instruction word
//   opcode_o  : internal opcode code (0 = unrecognised; all fields then 0)
//   rs1_o/rs2_o/rd_o : register fields, 0 where the format has no such field
//   imm_o     : sign-extended immediate for the format (shamt for shifts)
module instruction_fetcher_decoder
  import instruction_fetcher_pkg::*;
(
  input  logic [31:0] inst_i,
  output op_code_t    opcode_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt;

  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign imm_i_fmt = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_fmt = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_fmt = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_fmt = {inst_i[31:12], 12'b0};
  assign imm_j_fmt = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    opcode_o = OP_NONE;
    rs1_o    = 5'd0;
    rs2_o    = 5'd0;
    rd_o     = 5'd0;
    imm_o    = 32'd0;

    unique case (inst_i[6:0])
      RV_LUI:   begin opcode_o = OP_LUI;   rd_o = inst_i[11:7]; imm_o = imm_u_fmt; end
      RV_AUIPC: begin opcode_o = OP_AUIPC; rd_o = inst_i[11:7]; imm_o = imm_u_fmt; end
      RV_JAL:   begin opcode_o = OP_JAL;   rd_o = inst_i[11:7]; imm_o = imm_j_fmt; end
      RV_JALR: begin
        if (funct3 == 3'b000) opcode_o = OP_JALR;
        rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; imm_o = imm_i_fmt;
      end
      RV_BRANCH: begin
        case (funct3)
          3'b000:  opcode_o = OP_BEQ;
          3'b001:  opcode_o = OP_BNE;
          3'b100:  opcode_o = OP_BLT;
          3'b101:  opcode_o = OP_BGE;
          3'b110:  opcode_o = OP_BLTU;
          3'b111:  opcode_o = OP_BGEU;
          default: opcode_o = OP_NONE;
        endcase
        rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20]; imm_o = imm_b_fmt;
      end
      RV_LOAD: begin
        case (funct3)
          3'b000:  opcode_o = OP_LB;
          3'b001:  opcode_o = OP_LH;
          3'b010:  opcode_o = OP_LW;
          3'b100:  opcode_o = OP_LBU;
          3'b101:  opcode_o = OP_LHU;
          default: opcode_o = OP_NONE;
        endcase
        rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; imm_o = imm_i_fmt;
      end
      RV_STORE: begin
        case (funct3)
          3'b000:  opcode_o = OP_SB;
          3'b001:  opcode_o = OP_SH;
          3'b010:  opcode_o = OP_SW;
          default: opcode_o = OP_NONE;
        endcase
        rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20]; imm_o = imm_s_fmt;
      end
      RV_OPIMM: begin
        rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; imm_o = imm_i_fmt;
        case (funct3)
          3'b000: opcode_o = OP_ADDI;
          3'b010: opcode_o = OP_SLTI;
          3'b011: opcode_o = OP_SLTIU;
          3'b100: opcode_o = OP_XORI;
          3'b110: opcode_o = OP_ORI;
          3'b111: opcode_o = OP_ANDI;
          3'b001: begin
            if (funct7 == 7'b0000000) opcode_o = OP_SLLI;
            imm_o = {27'd0, inst_i[24:20]};
          end
          default: begin // 3'b101
            if (funct7 == 7'b0000000)      opcode_o = OP_SRLI;
            else if (funct7 == 7'b0100000) opcode_o = OP_SRAI;
            imm_o = {27'd0, inst_i[24:20]};
          end
        endcase
      end
      RV_OP: begin
        rd_o = inst_i[11:7]; rs1_o = inst_i[19:15]; rs2_o = inst_i[24:20];
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  opcode_o = OP_ADD;
            3'b001:  opcode_o = OP_SLL;
            3'b010:  opcode_o = OP_SLT;
            3'b011:  opcode_o = OP_SLTU;
            3'b100:  opcode_o = OP_XOR;
            3'b101:  opcode_o = OP_SRL;
            3'b110:  opcode_o = OP_OR;
            default: opcode_o = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      opcode_o = OP_SUB;
          else if (funct3 == 3'b101) opcode_o = OP_SRA;
        end
      end
      default: opcode_o = OP_NONE;
    endcase

    // Unrecognised words carry no fields at all.
    if (opcode_o == OP_NONE) begin
      rs1_o = 5'd0;
      rs2_o = 5'd0;
      rd_o  = 5'd0;
      imm_o = 32'd0;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the fetch PC, requests words from the instruction cache,
// decodes them and holds one decoded instruction for the dispatcher.
// Static prediction: jal and backward branches taken; jalr stalls fetch until
// jalr_done; a RoB flush redirects fetch in any state.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   icache_req_valid/addr (out), icache_resp_valid/inst (in)
//   flush_valid/flush_pc (in), jalr_done/jalr_target (in)
//   issue_valid (out), issue_ready (in), issue_* decoded fields (out)
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [6:0]  issue_opcode,
  output logic [4:0]  issue_rs1,
  output logic [4:0]  issue_rs2,
  output logic [4:0]  issue_rd,
  output logic [31:0] issue_imm,
  output logic [31:0] issue_pc,
  output logic        issue_pred_taken,
  output logic [31:0] issue_pred_pc
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;        // fetch PC; also drives icache_req_addr
  logic [31:0]  redirect_q;  // flush target saved while draining
  logic         req_valid_q;
  logic         issue_valid_q;
  op_code_t     issue_opcode_q;
  logic [4:0]   issue_rs1_q, issue_rs2_q, issue_rd_q;
  logic [31:0]  issue_imm_q, issue_pc_q, issue_pred_pc_q;
  logic         issue_pred_taken_q;

  op_code_t     dec_opcode;
  logic [4:0]   dec_rs1, dec_rs2, dec_rd;
  logic [31:0]  dec_imm;
  logic         is_branch;
  logic         pred_taken_d;
  logic [31:0]  pred_pc_d;

  instruction_fetcher_decoder u_decoder (
    .inst_i   (icache_resp_inst),
    .opcode_o (dec_opcode),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .rd_o     (dec_rd),
    .imm_o    (dec_imm)
  );

  // Static prediction from the word being returned for pc_q.
  assign is_branch    = (dec_opcode >= OP_BEQ) && (dec_opcode <= OP_BGEU);
  assign pred_taken_d = (dec_opcode == OP_JAL) || (is_branch && dec_imm[31]);
  assign pred_pc_d    = pred_taken_d ? (pc_q + dec_imm) : (pc_q + 32'd4);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q            <= ST_IDLE;
      pc_q               <= RESET_PC;
      redirect_q         <= RESET_PC;
      req_valid_q        <= 1'b0;
      issue_valid_q      <= 1'b0;
      issue_opcode_q     <= OP_NONE;
      issue_rs1_q        <= 5'd0;
      issue_rs2_q        <= 5'd0;
      issue_rd_q         <= 5'd0;
      issue_imm_q        <= 32'd0;
      issue_pc_q         <= 32'd0;
      issue_pred_pc_q    <= 32'd0;
      issue_pred_taken_q <= 1'b0;
    end else if (rdy_in) begin
      // NOTE: state registers use non-blocking assignments so every branch
      // below sees the pre-edge values of pc_q and friends.
      unique case (state_q)
        ST_IDLE: begin
          if (flush_valid) pc_q <= flush_pc;
          req_valid_q <= 1'b1;
          state_q     <= ST_REQ;
        end

        ST_REQ: begin
          if (flush_valid) begin
            if (icache_resp_valid) begin
              // Response already here: drop it and request the target now.
              pc_q <= flush_pc;
            end else begin
              // Outstanding request must complete before re-requesting.
              redirect_q <= flush_pc;
              state_q    <= ST_DRAIN;
            end
          end else if (icache_resp_valid) begin
            issue_opcode_q     <= dec_opcode;
            issue_rs1_q        <= dec_rs1;
            issue_rs2_q        <= dec_rs2;
            issue_rd_q         <= dec_rd;
            issue_imm_q        <= dec_imm;
            issue_pc_q         <= pc_q;
            issue_pred_pc_q    <= pred_pc_d;
            issue_pred_taken_q <= pred_taken_d;
            issue_valid_q      <= 1'b1;
            req_valid_q        <= 1'b0;
            state_q            <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (flush_valid) begin
            pc_q          <= flush_pc;
            issue_valid_q <= 1'b0;
            req_valid_q   <= 1'b1;
            state_q       <= ST_REQ;
          end else if (issue_ready) begin
            issue_valid_q <= 1'b0;
            if (issue_opcode_q == OP_JALR) begin
              state_q <= ST_JALR;
            end else begin
              pc_q        <= issue_pred_pc_q;
              req_valid_q <= 1'b1;
              state_q     <= ST_REQ;
            end
          end
        end

        ST_JALR: begin
          if (flush_valid || jalr_done) begin
            pc_q        <= flush_valid ? flush_pc : jalr_target;
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end

        ST_DRAIN: begin
          if (flush_valid) redirect_q <= flush_pc;
          if (icache_resp_valid) begin
            // A flush arriving with the drained word still wins.
            pc_q    <= flush_valid ? flush_pc : redirect_q;
            state_q <= ST_REQ;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign icache_req_valid = req_valid_q;
  assign icache_req_addr  = pc_q;
  assign issue_valid      = issue_valid_q;
  assign issue_opcode     = issue_opcode_q;
  assign issue_rs1        = issue_rs1_q;
  assign issue_rs2        = issue_rs2_q;
  assign issue_rd         = issue_rd_q;
  assign issue_imm        = issue_imm_q;
  assign issue_pc         = issue_pc_q;
  assign issue_pred_taken = issue_pred_taken_q;
  assign issue_pred_pc    = issue_pred_pc_q;

endmodule
